mem_stage: RTL and testbench

Pipeline stage directly downstream of the execute stage in the 5-stage in-order core. It holds one instruction and takes the synchronous data-SRAM read data for loads. It aligns and extends that data by load type and passes the write-back result to the WB stage. A one-entry read-data buffer keeps load data intact while WB back-pressures, and a forward bus feeds decode bypass.

---
 rtl/mem_stage.sv | 121 ++++++++++++
 tb/tb_mem_stage.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// Memory stage: aligns/extends load data, buffers it under WB stall,
// and drives the write-back bus and the decode forward bus.
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 76,
    parameter int MS_TO_WS_BUS_WD = 70,
    parameter int MS_FWD_BUS_WD   = 38
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic [MS_FWD_BUS_WD-1:0]   ms_fwd_bus
);

    logic                       ms_valid_q, ms_valid_d;
    logic                       ms_first_q, ms_first_d;
    logic [ES_TO_MS_BUS_WD-1:0] ms_bus_q, ms_bus_d;
    logic [31:0]                rbuf_q, rbuf_d;
    logic                       rbuf_valid_q, rbuf_valid_d;

    logic        ms_ready_go;
    logic        accept;
    logic [2:0]  ld_type;
    logic [1:0]  addr_lo;
    logic        res_from_mem;
    logic        gr_we;
    logic [4:0]  dest;
    logic [31:0] ex_result;
    logic [31:0] pc;
    logic [31:0] mem_word;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_data;
    logic [31:0] final_result;

    assign ld_type      = ms_bus_q[75:73];
    assign addr_lo      = ms_bus_q[72:71];
    assign res_from_mem = ms_bus_q[70];
    assign gr_we        = ms_bus_q[69];
    assign dest         = ms_bus_q[68:64];
    assign ex_result    = ms_bus_q[63:32];
    assign pc           = ms_bus_q[31:0];

    // The stage never needs extra cycles: SRAM data arrives in the first cycle.
    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = !ms_valid_q || (ms_ready_go && ws_allowin);
    assign ms_to_ws_valid = ms_valid_q && ms_ready_go;
    assign accept         = es_to_ms_valid && ms_allowin;

    // Next-state for the occupancy, first-cycle flag, bus and read buffer.
    always_comb begin
        ms_valid_d   = ms_valid_q;
        ms_first_d   = 1'b0;
        ms_bus_d     = ms_bus_q;
        rbuf_d       = rbuf_q;
        rbuf_valid_d = rbuf_valid_q;
        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end
        if (accept) begin
            ms_bus_d   = es_to_ms_bus;
            ms_first_d = 1'b1;
        end
        if (accept || ms_allowin) begin
            rbuf_valid_d = 1'b0;
        end else if (ms_valid_q && ms_first_q && res_from_mem && !ws_allowin) begin
            // Live rdata is only good for one cycle; hold it while WB stalls.
            rbuf_d       = data_sram_rdata;
            rbuf_valid_d = 1'b1;
        end
    end

    // Control flops with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ms_valid_q   <= 1'b0;
            ms_first_q   <= 1'b0;
            rbuf_valid_q <= 1'b0;
        end else begin
            ms_valid_q   <= ms_valid_d;
            ms_first_q   <= ms_first_d;
            rbuf_valid_q <= rbuf_valid_d;
        end
    end

    // Datapath flops; contents are qualified by the control flops.
    always_ff @(posedge clk) begin
        ms_bus_q <= ms_bus_d;
        rbuf_q   <= rbuf_d;
    end

    // Select load word, then align and extend by load type.
    always_comb begin
        mem_word = rbuf_valid_q ? rbuf_q : data_sram_rdata;
        ld_byte  = mem_word[7:0];
        case (addr_lo)
            2'd1:    ld_byte = mem_word[15:8];
            2'd2:    ld_byte = mem_word[23:16];
            2'd3:    ld_byte = mem_word[31:24];
            default: ld_byte = mem_word[7:0];
        endcase
        ld_half = addr_lo[1] ? mem_word[31:16] : mem_word[15:0];
        case (ld_type)
            3'd1:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd2:    ld_data = {24'd0, ld_byte};
            3'd3:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_data = {16'd0, ld_half};
            default: ld_data = mem_word;
        endcase
        final_result = res_from_mem ? ld_data : ex_result;
    end

    assign ms_to_ws_bus = {gr_we, dest, final_result, pc};
    assign ms_fwd_bus   = {ms_valid_q && gr_we, dest, final_result};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases from the load rules
// plus randomized traffic against a one-slot behavioural model.
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [75:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [31:0] data_sram_rdata;
    logic [37:0] ms_fwd_bus;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .data_sram_rdata (data_sram_rdata),
        .ms_fwd_bus      (ms_fwd_bus)
    );

    function automatic logic [75:0] mk_bus(input logic [2:0] lt,
                                           input logic [1:0] alo,
                                           input logic rfm, input logic we,
                                           input logic [4:0] dst,
                                           input logic [31:0] res,
                                           input logic [31:0] pc);
        return {lt, alo, rfm, we, dst, res, pc};
    endfunction

    // Reference load semantics: shift out the addressed unit, then extend.
    function automatic logic [31:0] ref_load(input logic [2:0] lt,
                                             input logic [1:0] alo,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = 8'(w >> (8 * alo));
        h = 16'(w >> (16 * alo[1]));
        case (lt)
            3'd1:    return 32'($signed(b));
            3'd2:    return 32'(b);
            3'd3:    return 32'($signed(h));
            3'd4:    return 32'(h);
            default: return w;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ws_allowin = 1'b1;
        es_to_ms_valid = 1'b0;
        es_to_ms_bus = '0;
        data_sram_rdata = '0;
        tick();
        tick();
        @(negedge clk);
        n_tests++;
        if (ms_to_ws_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_valid got=%b exp=0", ms_to_ws_valid);
        end
        n_tests++;
        if (ms_fwd_bus[37] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fwd got=%b exp=0", ms_fwd_bus[37]);
        end
        n_tests++;
        if (ms_allowin !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_allowin got=%b exp=1", ms_allowin);
        end
        tick();
        reset = 1'b0;
    endtask

    task automatic test_loads();
        logic [2:0]  lt  [4] = '{3'd1, 3'd2, 3'd3, 3'd4};
        logic [1:0]  alo [4] = '{2'd3, 2'd3, 2'd2, 2'd0};
        logic [31:0] rd  [4] = '{32'h80FF_1234, 32'h80FF_1234,
                                 32'h8001_7FFF, 32'h8001_7FFF};
        logic [31:0] ex  [4] = '{32'hFFFF_FF80, 32'h0000_0080,
                                 32'hFFFF_8001, 32'h0000_7FFF};
        ws_allowin = 1'b1;
        for (int i = 0; i < 4; i++) begin
            es_to_ms_valid = 1'b1;
            es_to_ms_bus = mk_bus(lt[i], alo[i], 1'b1, 1'b1, 5'd7,
                                  32'h5555_5555, 32'h100 + 32'(i));
            tick();
            es_to_ms_valid = 1'b0;
            data_sram_rdata = rd[i];
            @(negedge clk);
            n_tests++;
            if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== ex[i]) begin
                n_fail++;
                $display("FAIL load_%0d got=%b/%h exp=1/%h", i,
                         ms_to_ws_valid, ms_to_ws_bus[63:32], ex[i]);
            end
            tick();
        end
    endtask

    task automatic test_stall();
        int emitted = 0;
        ws_allowin = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(3'd0, 2'd0, 1'b1, 1'b1, 5'd9, 32'h0, 32'h200);
        tick();
        es_to_ms_valid = 1'b0;
        data_sram_rdata = 32'hDEAD_BEEF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF || ms_allowin !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_%0d got=%h/%b exp=deadbeef/0", k,
                         ms_to_ws_bus[63:32], ms_allowin);
            end
            tick();
            data_sram_rdata = 32'h0;
        end
        ws_allowin = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (ms_to_ws_valid === 1'b1) begin
                emitted++;
                n_tests++;
                if (ms_to_ws_bus[63:32] !== 32'hDEAD_BEEF) begin
                    n_fail++;
                    $display("FAIL stall_release got=%h exp=deadbeef",
                             ms_to_ws_bus[63:32]);
                end
            end
            tick();
        end
        n_tests++;
        if (emitted != 1) begin
            n_fail++;
            $display("FAIL stall_emit_count got=%0d exp=1", emitted);
        end
    endtask

    task automatic test_alu();
        ws_allowin = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(3'd0, 2'd0, 1'b0, 1'b1, 5'd5, 32'h1234, 32'h300);
        tick();
        es_to_ms_valid = 1'b0;
        data_sram_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        n_tests++;
        if (ms_to_ws_bus[63:32] !== 32'h1234) begin
            n_fail++;
            $display("FAIL alu_result got=%h exp=1234", ms_to_ws_bus[63:32]);
        end
        n_tests++;
        if (ms_fwd_bus !== {1'b1, 5'd5, 32'h1234}) begin
            n_fail++;
            $display("FAIL alu_fwd got=%h exp=%h", ms_fwd_bus,
                     {1'b1, 5'd5, 32'h1234});
        end
        tick();
    endtask

    task automatic test_reset_mid();
        ws_allowin = 1'b0;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(3'd0, 2'd0, 1'b1, 1'b1, 5'd3, 32'h0, 32'h400);
        tick();
        es_to_ms_valid = 1'b0;
        data_sram_rdata = 32'h1111_2222;
        tick();
        data_sram_rdata = 32'h0;
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        n_tests++;
        if (ms_to_ws_valid !== 1'b0 || ms_fwd_bus[37] !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid got=%b/%b exp=0/0",
                     ms_to_ws_valid, ms_fwd_bus[37]);
        end
        ws_allowin = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(3'd0, 2'd0, 1'b1, 1'b1, 5'd3, 32'h0, 32'h404);
        tick();
        es_to_ms_valid = 1'b0;
        data_sram_rdata = 32'hCAFE_0000;
        @(negedge clk);
        n_tests++;
        if (ms_to_ws_bus[63:32] !== 32'hCAFE_0000) begin
            n_fail++;
            $display("FAIL reset_mid_lw got=%h exp=cafe0000",
                     ms_to_ws_bus[63:32]);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        ws_allowin = 1'b1;
        es_to_ms_valid = 1'b1;
        es_to_ms_bus = mk_bus(3'd0, 2'd0, 1'b1, 1'b1, 5'd1, 32'h0, 32'h500);
        tick();
        for (int i = 0; i < 8; i++) begin
            w = $urandom;
            data_sram_rdata = w;
            es_to_ms_bus = mk_bus(3'd0, 2'd0, 1'b1, 1'b1, 5'd1, 32'h0,
                                  32'h504 + 32'(4 * i));
            es_to_ms_valid = (i < 7);
            @(negedge clk);
            n_tests++;
            if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus[63:32] !== w) begin
                n_fail++;
                $display("FAIL b2b_%0d got=%b/%h exp=1/%h", i,
                         ms_to_ws_valid, ms_to_ws_bus[63:32], w);
            end
            tick();
        end
    endtask

    // One-slot model: an instruction's load word is the rdata seen in its
    // first cycle in the stage, however long WB then stalls it.
    task automatic test_random();
        logic        m_have = 1'b0;
        logic        m_first = 1'b0;
        logic [75:0] m_inst = '0;
        logic [31:0] m_word = '0;
        logic [31:0] m_res;
        logic        m_allow;
        reset = 1'b1;
        es_to_ms_valid = 1'b0;
        tick();
        reset = 1'b0;
        for (int c = 0; c < 600; c++) begin
            es_to_ms_valid = ($urandom_range(0, 3) != 0);
            ws_allowin = ($urandom_range(0, 2) != 0);
            es_to_ms_bus = {3'($urandom_range(0, 7)), 73'({$urandom, $urandom, $urandom})};
            data_sram_rdata = $urandom;
            @(negedge clk);
            if (m_first) m_word = data_sram_rdata;
            m_res = m_inst[70] ? ref_load(m_inst[75:73], m_inst[72:71], m_word)
                               : m_inst[63:32];
            m_allow = !m_have || ws_allowin;
            n_tests++;
            if (ms_allowin !== m_allow || ms_to_ws_valid !== m_have) begin
                n_fail++;
                $display("FAIL rnd_hs c=%0d got=%b/%b exp=%b/%b", c,
                         ms_allowin, ms_to_ws_valid, m_allow, m_have);
            end
            if (m_have) begin
                n_tests++;
                if (ms_to_ws_bus !== {m_inst[69:64], m_res, m_inst[31:0]} ||
                    ms_fwd_bus !== {1'b1 & m_inst[69], m_inst[68:64], m_res}) begin
                    n_fail++;
                    $display("FAIL rnd_data c=%0d got=%h/%h exp=%h/%h", c,
                             ms_to_ws_bus, ms_fwd_bus,
                             {m_inst[69:64], m_res, m_inst[31:0]},
                             {m_inst[69], m_inst[68:64], m_res});
                end
            end else begin
                n_tests++;
                if (ms_fwd_bus[37] !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rnd_fwd_idle c=%0d got=%b exp=0", c,
                             ms_fwd_bus[37]);
                end
            end
            m_first = 1'b0;
            if (m_allow) begin
                m_have = es_to_ms_valid;
                if (es_to_ms_valid) begin
                    m_inst = es_to_ms_bus;
                    m_first = 1'b1;
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_loads();
        test_stall();
        test_alu();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
